// File: rtl/vc_pop_scheduler_pkg.sv
// Shared definitions for the VC pop scheduler and its arbiter.
package vc_pop_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } sched_state_t;

   localparam logic VC0 = 1'b0;
   localparam logic VC1 = 1'b1;

   localparam int unsigned DEF_W0 = 4;
   localparam int unsigned DEF_W1 = 2;

endpackage

// File: rtl/vc_pop_scheduler_rr_arb2.sv
// Combinational two-requester arbiter: urgency first, then round robin
// against the last-served requester.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic [1:0] i_urg,
   input  logic       i_last,
   output logic       o_gnt,
   output logic       o_valid
);
   import vc_pop_scheduler_pkg::*;

   always_comb begin
      o_valid = |i_req;
      o_gnt   = VC0;
      if (i_req == 2'b11) begin
         if (i_urg == 2'b01)      o_gnt = VC0;
         else if (i_urg == 2'b10) o_gnt = VC1;
         else                     o_gnt = ~i_last;
      end else if (i_req[1]) begin
         o_gnt = VC1;
      end
   end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Weighted round-robin pop scheduler for the VC0/VC1 FIFOs; at most one
// registered pop per cycle, with per-VC saturating pop counters.
module vc_pop_scheduler
   import vc_pop_scheduler_pkg::*;
#(
   parameter int unsigned W_WIDTH   = 4,
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned W0_RST    = DEF_W0,
   parameter int unsigned W1_RST    = DEF_W1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cfg_load,
   input  logic [W_WIDTH-1:0]   cfg_w0,
   input  logic [W_WIDTH-1:0]   cfg_w1,
   input  logic                 vc0_empty,
   input  logic                 vc0_almost_empty,
   input  logic                 vc0_almost_full,
   input  logic                 vc1_empty,
   input  logic                 vc1_almost_empty,
   input  logic                 vc1_almost_full,
   input  logic                 d0_pause,
   input  logic                 d1_pause,
   output logic                 pop_vc0,
   output logic                 pop_vc1,
   output logic                 grant_vc,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pop_cnt0,
   output logic [CNT_WIDTH-1:0] pop_cnt1
);

   sched_state_t         r_state, w_state_n;
   logic [W_WIDTH-1:0]   r_cnt, w_cnt_n;
   logic [W_WIDTH-1:0]   r_wact, w_wact_n;
   logic [W_WIDTH-1:0]   r_w0_sh, r_w1_sh;
   logic                 r_last, w_last_n;
   logic                 r_grant, w_grant_n;
   logic                 r_pop0, w_pop0_n;
   logic                 r_pop1, w_pop1_n;
   logic                 r_pause;
   logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

   logic w_stall, w_elig0, w_elig1, w_start;
   logic w_arb_gnt, w_arb_valid;

   function automatic logic [W_WIDTH-1:0] eff_w(input logic [W_WIDTH-1:0] w);
      return (w == '0) ? W_WIDTH'(1) : w;
   endfunction

   assign w_stall = !enable | r_pause;
   // A VC just popped while almost empty may hold its last entry: skip one cycle.
   assign w_elig0 = !vc0_empty & !(r_pop0 & vc0_almost_empty);
   assign w_elig1 = !vc1_empty & !(r_pop1 & vc1_almost_empty);

   rr_arb2 u_arb (
      .i_req   ({w_elig1, w_elig0}),
      .i_urg   ({vc1_almost_full, vc0_almost_full}),
      .i_last  (r_last),
      .o_gnt   (w_arb_gnt),
      .o_valid (w_arb_valid)
   );

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_wact_n  = r_wact;
      w_last_n  = r_last;
      w_grant_n = r_grant;
      w_pop0_n  = 1'b0;
      w_pop1_n  = 1'b0;
      w_start   = 1'b0;

      case (r_state)
         IDLE: w_start = !w_stall;
         SERVE0: begin
            if (!w_stall) begin
               if (!w_elig0) begin
                  w_start = 1'b1;
               end else begin
                  w_pop0_n = 1'b1;
                  if ((r_cnt == r_wact) || (vc1_almost_full && !vc0_almost_full))
                     w_start = 1'b1;
                  else
                     w_cnt_n = r_cnt + 1'b1;
               end
            end
         end
         SERVE1: begin
            if (!w_stall) begin
               if (!w_elig1) begin
                  w_start = 1'b1;
               end else begin
                  w_pop1_n = 1'b1;
                  if ((r_cnt == r_wact) || (vc0_almost_full && !vc1_almost_full))
                     w_start = 1'b1;
                  else
                     w_cnt_n = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_n = IDLE;
      endcase

      // Burst end and idle exit share one arbitration; weight latched here only.
      if (w_start) begin
         if (w_arb_valid) begin
            w_state_n = w_arb_gnt ? SERVE1 : SERVE0;
            w_cnt_n   = W_WIDTH'(1);
            w_grant_n = w_arb_gnt;
            w_last_n  = w_arb_gnt;
            w_wact_n  = eff_w(w_arb_gnt ? r_w1_sh : r_w0_sh);
         end else begin
            w_state_n = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wact  <= '0;
         r_w0_sh <= W_WIDTH'(W0_RST);
         r_w1_sh <= W_WIDTH'(W1_RST);
         r_last  <= VC1;
         r_grant <= VC0;
         r_pop0  <= 1'b0;
         r_pop1  <= 1'b0;
         r_pause <= 1'b0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_wact  <= w_wact_n;
         r_last  <= w_last_n;
         r_grant <= w_grant_n;
         r_pop0  <= w_pop0_n;
         r_pop1  <= w_pop1_n;
         r_pause <= d0_pause | d1_pause;
         if (cfg_load) begin
            r_w0_sh <= cfg_w0;
            r_w1_sh <= cfg_w1;
         end
         if (w_pop0_n && !(&r_cnt0)) r_cnt0 <= r_cnt0 + 1'b1;
         if (w_pop1_n && !(&r_cnt1)) r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   assign pop_vc0  = r_pop0;
   assign pop_vc1  = r_pop1;
   assign grant_vc = r_grant;
   assign busy     = (r_state != IDLE);
   assign pop_cnt0 = r_cnt0;
   assign pop_cnt1 = r_cnt1;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: FIFO occupancy environment, burst-level
// reference model, scenario table, corner sequences and random traffic.
module tb_vc_pop_scheduler;

   logic       clk;
   logic       reset, enable, cfg_load;
   logic [3:0] cfg_w0, cfg_w1;
   logic       vc0_empty, vc0_almost_empty, vc0_almost_full;
   logic       vc1_empty, vc1_almost_empty, vc1_almost_full;
   logic       d0_pause, d1_pause;
   logic       pop_vc0, pop_vc1, grant_vc, busy;
   logic [7:0] pop_cnt0, pop_cnt1;

   vc_pop_scheduler #(.W_WIDTH(4), .CNT_WIDTH(8), .W0_RST(4), .W1_RST(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
      .cfg_w0(cfg_w0), .cfg_w1(cfg_w1),
      .vc0_empty(vc0_empty), .vc0_almost_empty(vc0_almost_empty), .vc0_almost_full(vc0_almost_full),
      .vc1_empty(vc1_empty), .vc1_almost_empty(vc1_almost_empty), .vc1_almost_full(vc1_almost_full),
      .d0_pause(d0_pause), .d1_pause(d1_pause),
      .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .grant_vc(grant_vc), .busy(busy),
      .pop_cnt0(pop_cnt0), .pop_cnt1(pop_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // FIFO environment
   int occ[2];
   int af_th;

   // Reference model: who owns the burst and how many pops it has left
   int m_owner, m_left, m_last, m_grant;
   int m_cnt[2];
   int m_wsh[2];
   bit m_pop[2];
   bit m_pq;

   logic [63:0] seq;
   int          nseq;

   typedef struct {
      int          w0, w1, n0, n1, exp_n;
      logic [63:0] exp_seq;
      int          exp_c0, exp_c1;
   } wrr_vec_t;
   wrr_vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_flags();
      vc0_empty        = (occ[0] == 0);
      vc0_almost_empty = (occ[0] <= 1);
      vc0_almost_full  = (occ[0] >= af_th);
      vc1_empty        = (occ[1] == 0);
      vc1_almost_empty = (occ[1] <= 1);
      vc1_almost_full  = (occ[1] >= af_th);
   endtask

   function automatic int pick_vc(bit e0, bit e1, bit a0, bit a1, int last);
      if (e0 && e1) begin
         if (a0 && !a1) return 0;
         if (a1 && !a0) return 1;
         return 1 - last;
      end
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   task automatic model_step();
      bit stall, need;
      bit el[2], af[2], np[2];
      int v, p;
      if (reset) begin
         m_owner = -1; m_left = 0; m_last = 1; m_grant = 0;
         m_cnt[0] = 0; m_cnt[1] = 0; m_wsh[0] = 4; m_wsh[1] = 2;
         m_pop[0] = 0; m_pop[1] = 0; m_pq = 0;
      end else begin
         stall = !enable || m_pq;
         el[0] = !vc0_empty && !(m_pop[0] && vc0_almost_empty);
         el[1] = !vc1_empty && !(m_pop[1] && vc1_almost_empty);
         af[0] = vc0_almost_full;
         af[1] = vc1_almost_full;
         np[0] = 0; np[1] = 0; need = 0;
         if (m_owner < 0) begin
            need = !stall;
         end else if (!stall) begin
            v = m_owner;
            if (!el[v]) need = 1;
            else begin
               np[v] = 1;
               m_left--;
               if (m_left == 0 || (af[1-v] && !af[v])) need = 1;
            end
         end
         if (need) begin
            p = pick_vc(el[0], el[1], af[0], af[1], m_last);
            if (p < 0) m_owner = -1;
            else begin
               m_owner = p; m_last = p; m_grant = p;
               m_left  = (m_wsh[p] == 0) ? 1 : m_wsh[p];
            end
         end
         for (int i = 0; i < 2; i++) begin
            m_pop[i] = np[i];
            if (np[i] && m_cnt[i] < 255) m_cnt[i]++;
         end
         if (cfg_load) begin
            m_wsh[0] = int'(cfg_w0);
            m_wsh[1] = int'(cfg_w1);
         end
         m_pq = d0_pause | d1_pause;
      end
   endtask

   task automatic tick();
      bit p0, p1;
      logic [19:0] e, a;
      p0 = pop_vc0;
      p1 = pop_vc1;
      model_step();
      @(posedge clk);
      #1;
      // FIFOs consume the pop that was presented at this edge
      chk("no_underflow0", 64'(p0 && occ[0] == 0), 64'd0);
      chk("no_underflow1", 64'(p1 && occ[1] == 0), 64'd0);
      if (p0 && occ[0] > 0) occ[0]--;
      if (p1 && occ[1] > 0) occ[1]--;
      chk("exclusive_pop", 64'(pop_vc0 & pop_vc1), 64'd0);
      e = {m_pop[0], m_pop[1], 1'(m_grant), m_owner >= 0, 8'(m_cnt[0]), 8'(m_cnt[1])};
      a = {pop_vc0, pop_vc1, grant_vc, busy, pop_cnt0, pop_cnt1};
      chk("model_outs", 64'(a), 64'(e));
      if ((pop_vc0 || pop_vc1) && nseq < 64) begin
         seq[nseq] = pop_vc1;
         nseq++;
      end
      set_flags();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic load_cfg(input int w0, input int w1);
      cfg_load = 1'b1;
      cfg_w0   = 4'(w0);
      cfg_w1   = 4'(w1);
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic start_case(input int n0, input int n1, input int th);
      enable = 1'b0;
      do_reset(2);
      occ[0] = n0; occ[1] = n1; af_th = th;
      set_flags();
   endtask

   initial begin
      logic [10:0] pv;

      vecs[0] = '{4, 2, 10, 10, 20, 64'hFCC30, 10, 10};
      vecs[1] = '{1, 3,  4,  6, 10, 64'h000EE,  4,  6};
      vecs[2] = '{0, 0,  3,  2,  5, 64'h0000A,  3,  2};
      vecs[3] = '{4, 2,  0,  5,  5, 64'h0001F,  0,  5};

      reset = 1'b1; enable = 1'b1; cfg_load = 1'b0; cfg_w0 = '0; cfg_w1 = '0;
      d0_pause = 1'b0; d1_pause = 1'b0;
      occ[0] = 5; occ[1] = 5; af_th = 99;
      seq = '0; nseq = 0;
      set_flags();

      // reset held with both VCs holding data, then first pop two cycles later
      repeat (3) tick();
      chk("reset_outs", 64'({pop_vc0, pop_vc1, grant_vc, busy, pop_cnt0, pop_cnt1}), 64'd0);
      reset = 1'b0;
      tick();
      chk("first_pop_cyc1", 64'(pop_vc0), 64'd0);
      tick();
      chk("first_pop_cyc2", 64'(pop_vc0), 64'd1);

      // weighted round robin scenario table
      for (int i = 0; i < 4; i++) begin
         start_case(0, 0, 99);
         load_cfg(vecs[i].w0, vecs[i].w1);
         occ[0] = vecs[i].n0; occ[1] = vecs[i].n1;
         set_flags();
         seq = '0; nseq = 0;
         enable = 1'b1;
         repeat (60) tick();
         chk("wrr_seq",   seq,              vecs[i].exp_seq);
         chk("wrr_npops", 64'(nseq),        64'(vecs[i].exp_n));
         chk("wrr_cnt0",  64'(pop_cnt0),    64'(vecs[i].exp_c0));
         chk("wrr_cnt1",  64'(pop_cnt1),    64'(vecs[i].exp_c1));
      end

      // 5-cycle d1 pause mid-burst: one more pop, five idle cycles, remainder
      start_case(8, 0, 99);
      enable = 1'b1;
      for (int t = 1; t <= 11; t++) begin
         if (t == 4) d1_pause = 1'b1;
         if (t == 9) d1_pause = 1'b0;
         tick();
         pv[t-1] = pop_vc0;
      end
      chk("pause_pattern", 64'(pv), 64'h60E);

      // single-entry VC0: exactly one pop then idle
      start_case(1, 0, 99);
      enable = 1'b1;
      repeat (6) tick();
      chk("underflow_cnt0", 64'(pop_cnt0), 64'd1);
      chk("underflow_idle", 64'(busy), 64'd0);

      // VC1 turns urgent during a long VC0 burst
      start_case(5, 0, 6);
      load_cfg(8, 2);
      enable = 1'b1;
      repeat (3) tick();
      occ[1] = 7;
      set_flags();
      tick();
      chk("urg_last_pop0", 64'(pop_vc0), 64'd1);
      tick();
      chk("urg_serve1", 64'({pop_vc1, grant_vc, pop_cnt0}), 64'({1'b1, 1'b1, 8'd3}));

      // weight change mid-burst only affects later bursts
      start_case(8, 8, 99);
      seq = '0; nseq = 0;
      enable = 1'b1;
      repeat (2) tick();
      load_cfg(0, 2);
      repeat (18) tick();
      chk("cfg_seq", seq & 64'h1FF, 64'h1B0);

      // counter saturation
      start_case(1000, 0, 99);
      enable = 1'b1;
      repeat (310) tick();
      chk("sat_cnt0", 64'(pop_cnt0), 64'd255);

      // random traffic against the model
      start_case(0, 0, 6);
      for (int i = 0; i < 3000; i++) begin
         enable   = ($urandom_range(9) != 0);
         d0_pause = ($urandom_range(19) == 0);
         d1_pause = ($urandom_range(19) == 0);
         cfg_load = ($urandom_range(29) == 0);
         cfg_w0   = 4'($urandom_range(15));
         cfg_w1   = 4'($urandom_range(15));
         reset    = ($urandom_range(199) == 0);
         for (int v = 0; v < 2; v++)
            if (occ[v] < 8 && $urandom_range(9) < 4) occ[v]++;
         set_flags();
         tick();
      end
      reset = 1'b0; cfg_load = 1'b0; d0_pause = 1'b0; d1_pause = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vc_pop_scheduler.md
Name: vc_pop_scheduler

Overview:
- Weighted round-robin scheduler that generates the pop strobes for the VC0 and VC1 virtual-channel FIFOs.
- Sits between the VC FIFOs and the VC mux. Consumes their empty, almost-empty and almost-full flags plus the D0/D1 pause flags.
- Drives at most one pop per cycle and exposes per-VC pop counters for the FSM and the bench.

Parameters:
- W_WIDTH, 4, width of the per-VC weight (burst length) fields.
- CNT_WIDTH, 8, width of the saturating per-VC pop counters.
- W0_RST, 4, VC0 weight after reset.
- W1_RST, 2, VC1 weight after reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global pop permission (the top-level pop); 0 freezes scheduling.
- cfg_load  in  1  one-cycle strobe; capture cfg_w0/cfg_w1.
- cfg_w0  in  W_WIDTH  requested VC0 weight.
- cfg_w1  in  W_WIDTH  requested VC1 weight.
- vc0_empty  in  1  VC0 FIFO empty.
- vc0_almost_empty  in  1  VC0 FIFO at or below its low threshold.
- vc0_almost_full  in  1  VC0 FIFO at or above its high threshold.
- vc1_empty  in  1  VC1 FIFO empty.
- vc1_almost_empty  in  1  VC1 FIFO at or below its low threshold.
- vc1_almost_full  in  1  VC1 FIFO at or above its high threshold.
- d0_pause  in  1  D0 FIFO pause.
- d1_pause  in  1  D1 FIFO pause.
- pop_vc0  out  1  registered pop strobe to VC0.
- pop_vc1  out  1  registered pop strobe to VC1.
- grant_vc  out  1  VC currently owning the burst (0 = VC0, 1 = VC1).
- busy  out  1  1 in SERVE0/SERVE1.
- pop_cnt0  out  CNT_WIDTH  saturating count of VC0 pops.
- pop_cnt1  out  CNT_WIDTH  saturating count of VC1 pops.

Behaviour:
- Reset (synchronous, high):
  - pop_vc0 = 0, pop_vc1 = 0, grant_vc = 0, busy = 0.
  - pop_cnt0 = 0, pop_cnt1 = 0.
  - Weights = W0_RST / W1_RST, burst counter = 0, state = IDLE.
  - Reset mid-burst drops the burst immediately. Pops return to 0 in the cycle after reset is sampled.
- Stall condition: stall = !enable | d0_pause | d1_pause, sampled each cycle. The pause input is registered once internally, giving a 1-cycle pause latency.
- Eligibility:
  - elig0 = !vc0_empty & !(pop_vc0 & vc0_almost_empty).
  - elig1 is defined the same way for VC1.
  - This forbids a back-to-back pop that could underflow a FIFO holding one entry.
- States:
  - IDLE: neither VC eligible, or stall.
  - SERVE0 / SERVE1: bursting the granted VC.
- IDLE exits when !stall and a VC is eligible:
  - Both eligible: urgency first (the VC with almost_full while the other does not); otherwise the VC not served last (round robin). VC0 wins the very first arbitration after reset.
  - Enter SERVEx, burst counter = 1, pop_vcx = 1 on the next edge.
- In SERVEx:
  - Each cycle with !stall and eligx: pop_vcx = 1 and burst counter increments.
  - The burst ends when the counter reaches Wx, or eligx = 0. The next state is chosen by the IDLE rules, with the last-served VC = x.
  - Urgency preemption: if the other VC raises almost_full while x does not, the burst ends after the current pop.
  - stall in SERVEx: pops = 0, state and burst counter held. The burst resumes when stall clears.
- Weights:
  - A weight of 0 is treated as 1.
  - cfg_load captures new weights into shadow registers. They take effect at the next burst start, never mid-burst.
  - cfg_load concurrent with reset: reset wins.
- Invariants:
  - pop_vc0 & pop_vc1 never both 1.
  - A pop is never issued to an empty VC.
- Counters: increment on each pop and saturate at all-ones (no wrap).
- Latency: a flag change at edge N affects the pops driven at edge N+1.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2), VC id constants, default weights.
- Sub-module: rr_arb2. A combinational two-requester arbiter with urgency and last-served inputs, returning the grant and a valid flag, reused by the D0/D1 path later.

Test Plan:
- Reset: hold reset 3 cycles with both VCs non-empty -> all outputs 0. First pop_vc0 appears 2 cycles after reset drops with enable = 1.
- Weighted round robin:
  - Setup: W0 = 4, W1 = 2; 10 entries per VC; no pauses.
  - Expected grant pattern: 0,0,0,0,1,1,0,0,0,0,1,1,...
  - Expected totals at the end: pop_cnt0 = 10, pop_cnt1 = 10.
- Pause: assert d1_pause for 5 cycles mid-burst -> pops stop 1 cycle after the pause. The burst resumes with the remaining count and no extra pops.
- Underflow guard: VC0 holds 1 entry (almost_empty = 1, empty = 0) -> exactly one pop_vc0, no back-to-back pop. Scheduler returns to IDLE.
- Urgency: during a VC0 burst (W0 = 8), vc1_almost_full rises -> the burst ends after the current pop and SERVE1 is entered.
- Config/saturation:
  - cfg_load W0 = 0 mid-burst -> the current burst keeps its old weight; the next VC0 burst is 1 pop.
  - Force 300 VC0 pops -> pop_cnt0 = 255.
